// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped UART FIFOs, cycle counter and stop flag.
// One access per cycle; read data is registered and held across writes.
module mem_io_responder #(
  parameter int RAM_ADDR_BITS = 17,
  parameter int TXQ_BITS      = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  localparam int RAM_WORDS = 1 << RAM_ADDR_BITS;
  localparam int QDEPTH    = 1 << TXQ_BITS;
  localparam int CW        = TXQ_BITS + 1;

  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
  localparam logic [CW-1:0] QHIGH = CW'(QDEPTH - 2);
  localparam logic [CW-1:0] CONE  = CW'(1);
  localparam logic [TXQ_BITS-1:0] PONE = TXQ_BITS'(1);

  // Address decode
  logic                     io_sel;
  logic [15:0]              io_off;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic                     off_rx;
  logic                     off_c0;
  logic                     off_c1;
  logic                     off_c2;
  logic                     off_c3;
  logic                     rd_ram;
  logic                     rd_io;
  logic                     wr_ram;
  logic                     wr_tx;
  logic                     wr_stop;
  logic                     unused_addr;

  assign io_sel  = (cpu_addr[17:16] == 2'b11);
  assign io_off  = cpu_addr[15:0];
  assign ram_idx = cpu_addr[RAM_ADDR_BITS-1:0];
  assign off_rx  = (io_off == 16'h0000);
  assign off_c0  = (io_off == 16'h0004);
  assign off_c1  = (io_off == 16'h0005);
  assign off_c2  = (io_off == 16'h0006);
  assign off_c3  = (io_off == 16'h0007);

  assign rd_ram  = !cpu_wr && !io_sel;
  assign rd_io   = !cpu_wr && io_sel;
  assign wr_ram  = cpu_wr && !io_sel && !rst_in;
  assign wr_tx   = cpu_wr && io_sel && off_rx;
  assign wr_stop = cpu_wr && io_sel && off_c0;

  assign unused_addr = ^cpu_addr[31:18];

  // State
  logic [7:0]          ram_q [RAM_WORDS];
  logic [7:0]          ram_rd_q;
  logic [7:0]          txq_q [QDEPTH];

  logic [31:0]         cyc_q, cyc_d;
  logic [31:0]         snap_q, snap_d;
  logic                src_ram_q, src_ram_d;
  logic [7:0]          io_rd_q, io_rd_d;
  logic [TXQ_BITS-1:0] wp_q, wp_d;
  logic [TXQ_BITS-1:0] rp_q, rp_d;
  logic [CW-1:0]       qcnt_q, qcnt_d;
  logic                stop_q, stop_d;
  logic                ovf_q, ovf_d;

  // FIFO control
  logic       q_full;
  logic       push_req;
  logic       push;
  logic       pop;
  logic [7:0] push_data;

  assign q_full    = (qcnt_q == QFULL);
  assign tx_valid  = (qcnt_q != '0);
  assign tx_data   = txq_q[rp_q];
  assign pop       = tx_valid && tx_ready && !rst_in;
  // The stop marker bypasses the zero filter so the host sees end-of-run.
  assign push_req  = !rst_in &&
                     (wr_stop || (wr_tx && (cpu_wdata != 8'h00)));
  assign push_data = wr_stop ? 8'h00 : cpu_wdata;
  assign push      = push_req && (!q_full || pop);

  assign rx_ready  = rd_io && off_rx && rx_valid && !rst_in;

  // IO read mux
  logic [7:0] io_rd;

  always_comb begin
    io_rd = 8'h00;
    unique case (1'b1)
      off_rx:  io_rd = rx_valid ? rx_data : 8'h00;
      off_c0:  io_rd = cyc_q[7:0];
      off_c1:  io_rd = snap_q[15:8];
      off_c2:  io_rd = snap_q[23:16];
      off_c3:  io_rd = snap_q[31:24];
      default: io_rd = 8'h00;
    endcase
  end

  // Next state
  always_comb begin
    cyc_d     = cyc_q + 32'd1;
    snap_d    = snap_q;
    src_ram_d = src_ram_q;
    io_rd_d   = io_rd_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    qcnt_d    = qcnt_q;
    stop_d    = stop_q;
    ovf_d     = ovf_q;

    if (rd_ram) begin
      src_ram_d = 1'b1;
    end
    if (rd_io) begin
      src_ram_d = 1'b0;
      io_rd_d   = io_rd;
    end
    // Byte 0 read freezes the whole count so bytes 1-3 stay coherent.
    if (rd_io && off_c0) begin
      snap_d = cyc_q;
    end

    if (wr_stop) begin
      stop_d = 1'b1;
    end
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end

    if (push) begin
      wp_d = wp_q + PONE;
    end
    if (pop) begin
      rp_d = rp_q + PONE;
    end
    unique case ({push, pop})
      2'b10:   qcnt_d = qcnt_q + CONE;
      2'b01:   qcnt_d = qcnt_q - CONE;
      default: qcnt_d = qcnt_q;
    endcase
  end

  // Registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_q     <= 32'd0;
      snap_q    <= 32'd0;
      src_ram_q <= 1'b0;
      io_rd_q   <= 8'h00;
      wp_q      <= '0;
      rp_q      <= '0;
      qcnt_q    <= '0;
      stop_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      snap_q    <= snap_d;
      src_ram_q <= src_ram_d;
      io_rd_q   <= io_rd_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      qcnt_q    <= qcnt_d;
      stop_q    <= stop_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage arrays keep their contents through reset.
  always_ff @(posedge clk_in) begin
    if (wr_ram) begin
      ram_q[ram_idx] <= cpu_wdata;
    end
    if (rd_ram) begin
      ram_rd_q <= ram_q[ram_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      txq_q[wp_q] <= push_data;
    end
  end

  // Outputs
  assign cpu_rdata      = src_ram_q ? ram_rd_q : io_rd_q;
  assign io_buffer_full = (qcnt_q >= QHIGH);
  assign prog_stop      = stop_q;
  assign tx_overflow    = ovf_q;

endmodule
